// File: rtl/sort_floats_n_using_fsm.sv
// Bubble sorter for N floating-point values, one compare-and-swap per cycle.
// Comparisons go through an external f_less_or_equal; results leave via valid/ready.
module sort_floats_n_using_fsm #(
    parameter int N    = 4,
    parameter int FLEN = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_in,
    output logic                     ready_in,
    input  logic                     descending,
    input  logic [0:N-1][FLEN-1:0]   unsorted,
    output logic                     valid_out,
    input  logic                     ready_out,
    output logic [0:N-1][FLEN-1:0]   sorted,
    output logic                     err,
    output logic                     busy,
    output logic [FLEN-1:0]          f_le_a,
    output logic [FLEN-1:0]          f_le_b,
    input  logic                     f_le_res,
    input  logic                     f_le_err
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 2);

    typedef enum logic [1:0] {
        IDLE,
        SORT,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [0:N-1][FLEN-1:0] data_q, data_nxt;
    logic [CW-1:0] pass_q, pass_nxt;
    logic [CW-1:0] idx_q, idx_nxt, idx_p1;
    logic          dir_q, dir_nxt;
    logic          err_q, err_nxt;
    logic [FLEN-1:0] lo, hi;
    logic          swap;
    logic          pass_end;

    assign idx_p1   = idx_q + CW'(1);
    assign lo       = data_q[idx_q];
    assign hi       = data_q[idx_p1];
    assign pass_end = (idx_q == LAST - pass_q);

    always_comb begin
        state_nxt = state;
        data_nxt  = data_q;
        pass_nxt  = pass_q;
        idx_nxt   = idx_q;
        dir_nxt   = dir_q;
        err_nxt   = err_q;
        f_le_a    = '0;
        f_le_b    = '0;
        swap      = 1'b0;
        case (state)
            IDLE: begin
                if (valid_in) begin
                    data_nxt  = unsorted;
                    dir_nxt   = descending;
                    pass_nxt  = '0;
                    idx_nxt   = '0;
                    err_nxt   = 1'b0;
                    state_nxt = SORT;
                end
            end
            SORT: begin
                // Descending swaps operands so "a <= b" still means "keep order".
                f_le_a = dir_q ? hi : lo;
                f_le_b = dir_q ? lo : hi;
                swap   = !f_le_res && !f_le_err;
                if (swap) begin
                    data_nxt[idx_q]  = hi;
                    data_nxt[idx_p1] = lo;
                end
                if (f_le_err) begin
                    err_nxt   = 1'b1;
                    state_nxt = DONE;
                end else if (pass_end) begin
                    idx_nxt = '0;
                    if (pass_q == LAST) begin
                        state_nxt = DONE;
                    end else begin
                        pass_nxt = pass_q + CW'(1);
                    end
                end else begin
                    idx_nxt = idx_p1;
                end
            end
            DONE: begin
                if (ready_out) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            data_q <= '0;
            pass_q <= '0;
            idx_q  <= '0;
            dir_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            data_q <= data_nxt;
            pass_q <= pass_nxt;
            idx_q  <= idx_nxt;
            dir_q  <= dir_nxt;
            err_q  <= err_nxt;
        end
    end

    assign ready_in  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign valid_out = (state == DONE);
    assign sorted    = data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_sort_floats_n_using_fsm.sv
// Randomized bench for sort_floats_n_using_fsm at N=2, 3 and 4.
// Expected results come from a stable insertion sort on real values.
module tb_sort_floats_n_using_fsm;

    typedef logic [0:3][63:0] vec_t;

    localparam logic [63:0] P1  = 64'h3FF0000000000000;
    localparam logic [63:0] P2  = 64'h4000000000000000;
    localparam logic [63:0] P25 = 64'h4004000000000000;
    localparam logic [63:0] P3  = 64'h4008000000000000;
    localparam logic [63:0] M1  = 64'hBFF0000000000000;
    localparam logic [63:0] M2  = 64'hC000000000000000;
    localparam logic [63:0] PZ  = 64'h0000000000000000;
    localparam logic [63:0] MZ  = 64'h8000000000000000;
    localparam logic [63:0] QN  = 64'h7FF8000000000000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic vin [2:4];
    logic rin [2:4];
    logic desc [2:4];
    logic vout [2:4];
    logic rout [2:4];
    logic errs [2:4];
    logic bsy [2:4];
    logic fres [2:4];
    logic ferr [2:4];
    logic [63:0] fa [2:4];
    logic [63:0] fb [2:4];

    logic [0:1][63:0] u2, s2;
    logic [0:2][63:0] u3, s3;
    logic [0:3][63:0] u4, s4;

    int chk_cnt = 0;
    int err_cnt = 0;

    function automatic logic [1:0] fle(input logic [63:0] a,
                                       input logic [63:0] b);
        logic na, nb;
        na = (a[62:52] == 11'h7ff) && (a[51:0] != '0);
        nb = (b[62:52] == 11'h7ff) && (b[51:0] != '0);
        if (na || nb) return 2'b10;
        return {1'b0, ($bitstoreal(a) <= $bitstoreal(b))};
    endfunction

    assign {ferr[2], fres[2]} = fle(fa[2], fb[2]);
    assign {ferr[3], fres[3]} = fle(fa[3], fb[3]);
    assign {ferr[4], fres[4]} = fle(fa[4], fb[4]);

    sort_floats_n_using_fsm #(.N(2), .FLEN(64)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .valid_in(vin[2]), .ready_in(rin[2]),
        .descending(desc[2]), .unsorted(u2),
        .valid_out(vout[2]), .ready_out(rout[2]),
        .sorted(s2), .err(errs[2]), .busy(bsy[2]),
        .f_le_a(fa[2]), .f_le_b(fb[2]),
        .f_le_res(fres[2]), .f_le_err(ferr[2])
    );

    sort_floats_n_using_fsm #(.N(3), .FLEN(64)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .valid_in(vin[3]), .ready_in(rin[3]),
        .descending(desc[3]), .unsorted(u3),
        .valid_out(vout[3]), .ready_out(rout[3]),
        .sorted(s3), .err(errs[3]), .busy(bsy[3]),
        .f_le_a(fa[3]), .f_le_b(fb[3]),
        .f_le_res(fres[3]), .f_le_err(ferr[3])
    );

    sort_floats_n_using_fsm #(.N(4), .FLEN(64)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .valid_in(vin[4]), .ready_in(rin[4]),
        .descending(desc[4]), .unsorted(u4),
        .valid_out(vout[4]), .ready_out(rout[4]),
        .sorted(s4), .err(errs[4]), .busy(bsy[4]),
        .f_le_a(fa[4]), .f_le_b(fb[4]),
        .f_le_res(fres[4]), .f_le_err(ferr[4])
    );

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic vec_t get_out(input int n);
        vec_t r;
        r = '0;
        case (n)
            2: begin r[0] = s2[0]; r[1] = s2[1]; end
            3: begin r[0] = s3[0]; r[1] = s3[1]; r[2] = s3[2]; end
            default: r = s4;
        endcase
        return r;
    endfunction

    task automatic set_in(input int n, input vec_t v);
        case (n)
            2: u2 = {v[0], v[1]};
            3: u3 = {v[0], v[1], v[2]};
            default: u4 = v;
        endcase
    endtask

    // Stable insertion sort: equal values keep their input order.
    function automatic vec_t model_sort(input int n, input vec_t v,
                                        input logic dir);
        logic [63:0] kb;
        int j;
        for (int i = 1; i < n; i++) begin
            kb = v[i];
            j = i - 1;
            while (j >= 0 && (dir ? ($bitstoreal(v[j]) < $bitstoreal(kb))
                                  : ($bitstoreal(v[j]) > $bitstoreal(kb)))) begin
                v[j+1] = v[j];
                j--;
            end
            v[j+1] = kb;
        end
        return v;
    endfunction

    function automatic int nan_pos(input int n, input vec_t v);
        for (int i = 0; i < n; i++) begin
            if (v[i][62:52] == 11'h7ff && v[i][51:0] != '0) return i;
        end
        return -1;
    endfunction

    task automatic start(input int n, input vec_t v, input logic dir);
        @(negedge clk);
        check("ready_in_before", 256'(rin[n]), 256'(1));
        set_in(n, v);
        desc[n] = dir;
        vin[n] = 1'b1;
        @(posedge clk);
        #1;
        vin[n] = 1'b0;
        desc[n] = ~dir;
    endtask

    task automatic run_vec(input int n, input vec_t vi, input logic dir,
                           input int hold);
        vec_t v, exp, snap;
        int p, lat, k;
        logic done, e_err;
        v = vi;
        for (int i = n; i < 4; i++) v[i] = '0;
        exp = model_sort(n, v, dir);
        p = nan_pos(n, v);
        e_err = (p >= 0);
        // A NaN is untouched until the first pass reaches the pair holding it.
        lat = e_err ? ((p > 0) ? p : 1) : n * (n - 1) / 2;
        start(n, v, dir);
        k = 0;
        done = 1'b0;
        while (!done && k < 200) begin
            @(posedge clk);
            k++;
            #1;
            done = vout[n];
        end
        check("latency", 256'(k), 256'(lat));
        check("err", 256'(errs[n]), 256'(e_err));
        if (!e_err) check("sorted", get_out(n), exp);
        snap = get_out(n);
        for (int h = 0; h < hold; h++) begin
            vin[n] = 1'($urandom_range(0, 1));
            rout[n] = 1'b0;
            @(posedge clk);
            #1;
            check("hold_valid", 256'(vout[n]), 256'(1));
            check("hold_ready_in", 256'(rin[n]), 256'(0));
            check("hold_sorted", get_out(n), snap);
            check("hold_err", 256'(errs[n]), 256'(e_err));
            check("hold_f_le_a", 256'(fa[n]), 256'(0));
        end
        vin[n] = 1'b0;
        rout[n] = 1'b1;
        @(posedge clk);
        #1;
        rout[n] = 1'b0;
        check("idle_valid", 256'(vout[n]), 256'(0));
        check("idle_busy", 256'(bsy[n]), 256'(0));
        check("idle_ready_in", 256'(rin[n]), 256'(1));
    endtask

    task automatic rst_mid(input int n, input vec_t v, input logic dir,
                           input int edges);
        start(n, v, dir);
        repeat (edges) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_valid", 256'(vout[n]), 256'(0));
        check("rst_busy", 256'(bsy[n]), 256'(0));
        check("rst_sorted", get_out(n), 256'(0));
        check("rst_err", 256'(errs[n]), 256'(0));
        #3;
        rst_n = 1'b1;
    endtask

    function automatic logic [63:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return M2;
            1: return M1;
            2: return MZ;
            3: return PZ;
            4: return P1;
            5: return P2;
            6: return P25;
            default: return P3;
        endcase
    endfunction

    initial begin
        vec_t v;
        int n;
        for (int i = 2; i <= 4; i++) begin
            vin[i] = 1'b0;
            rout[i] = 1'b0;
            desc[i] = 1'b0;
        end
        u2 = '0;
        u3 = '0;
        u4 = '0;
        #12;
        for (int i = 2; i <= 4; i++) begin
            check("reset_valid", 256'(vout[i]), 256'(0));
            check("reset_busy", 256'(bsy[i]), 256'(0));
            check("reset_err", 256'(errs[i]), 256'(0));
            check("reset_sorted", get_out(i), 256'(0));
            check("reset_ready_in", 256'(rin[i]), 256'(1));
            check("reset_f_le_b", 256'(fb[i]), 256'(0));
        end
        rst_n = 1'b1;

        run_vec(4, {P3, P1, M1, P2}, 1'b0, 0);
        run_vec(4, {P3, P1, M1, P2}, 1'b1, 0);
        run_vec(4, {P2, P1, P2, P1}, 1'b0, 1);
        run_vec(4, {PZ, MZ, P1, MZ}, 1'b0, 0);
        run_vec(4, {PZ, MZ, P1, MZ}, 1'b1, 2);
        run_vec(4, {P1, P3, QN, PZ}, 1'b0, 2);
        run_vec(4, {P3, P1, M1, P2}, 1'b0, 5);
        run_vec(3, {P3, P1, M1, PZ}, 1'b0, 1);
        run_vec(2, {P2, P1, PZ, PZ}, 1'b0, 1);
        run_vec(2, {P1, P2, PZ, PZ}, 1'b1, 0);

        rst_mid(4, {P3, P1, M1, P2}, 1'b0, 3);
        run_vec(4, {P3, P1, M1, P2}, 1'b1, 0);
        rst_mid(3, {P3, P1, M1, PZ}, 1'b1, 1);
        run_vec(3, {P3, P1, M1, PZ}, 1'b1, 0);
        rst_mid(2, {P2, P1, PZ, PZ}, 1'b0, 1);
        run_vec(2, {P2, P1, PZ, PZ}, 1'b0, 0);

        for (int it = 0; it < 60; it++) begin
            n = $urandom_range(2, 4);
            for (int i = 0; i < 4; i++) v[i] = rnd_val();
            if ($urandom_range(0, 7) == 0) v[$urandom_range(0, n - 1)] = QN;
            run_vec(n, v, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
